ultrasonic_io_slave: RTL and testbench
======================================

# ultrasonic_io_slave

Memory-mapped ultrasonic ranging peripheral that answers the J1 CPU I/O bus (io_rd/io_wr/io_addr/io_dout → io_din). It decodes its address window and holds control/status/result registers. It drives the sensor trigger pulse and measures the echo pulse width in microseconds. It sits beside the J1 core in the ultrasonido peripheral and is the responder end of the CPU's I/O port.

## Interface
Parameters:
- BASE_ADDR, 16'h6000, window base; the block is selected when io_addr[15:4] == BASE_ADDR[15:4].
- CLK_PER_US, 50, sys_clk_i cycles per microsecond; valid range 2..65535.
- TRIG_US, 10, trigger high time in µs.
- TIMEOUT_US, 30000, maximum µs from end of trigger to end of echo.

Ports:
- sys_clk_i  in  1  system clock; the only clock.
- sys_rst_i  in  1  synchronous, active-high reset.
- io_rd  in  1  CPU read strobe.
- io_wr  in  1  CPU write strobe. The CPU raises this for every store, so the address must be decoded.
- io_addr  in  16  CPU byte address.
- io_din  in  16  write data from CPU (CPU io_dout).
- io_dout  out  16  read data to CPU (CPU io_din); combinational.
- trig_o  out  1  sensor trigger; registered.
- echo_i  in  1  sensor echo; asynchronous.
- busy_o  out  1  measurement in progress; registered.

## Operation
- Register map, with offset = io_addr[3:0]:
  - 0x0 CTRL (W): bit0 = start. Write-one pulse, not stored. Reads return 0.
  - 0x2 STATUS (R): {13'b0, timeout, done, busy}.
  - 0x4 DATA (R): last echo width in µs.
  - Other offsets read 16'h0000. Writes to them, and writes to STATUS or DATA, are ignored.
- io_dout:
  - Selected register whenever the address is in the window; otherwise 16'h0000.
  - Purely combinational from io_addr and registers, independent of io_rd. The CPU samples it in the same cycle.
- echo_i is synchronized through 2 flops (echo_s) before any use.
- µs prescaler:
  - Counts 0..CLK_PER_US-1; tick asserts for one cycle when the count equals CLK_PER_US-1, then the counter wraps to 0.
  - Forced to 0 on an accepted start.
- FSM states and transitions:
  - IDLE: busy=0, trig_o=0. An accepted start (io_wr & selected & offset 0 & io_din[0]) clears done, timeout, µs counter and prescaler, then goes to TRIG.
  - TRIG: trig_o=1. After TRIG_US ticks, clear the µs counter and go to WAIT_RISE.
  - WAIT_RISE: if echo_s=1, go to MEASURE. On each tick increment the total counter; if it reaches TIMEOUT_US, go to FAIL.
  - MEASURE: on each tick increment the width counter and the total counter. When echo_s=0, go to DONE. If the total reaches TIMEOUT_US, go to FAIL.
  - DONE: DATA ← width counter, done=1, then go to IDLE (one cycle).
  - FAIL: DATA ← 16'hFFFF, timeout=1, done=1, then go to IDLE (one cycle).
- Counter widths: width and total counters are 16 bits. Width saturates at 16'hFFFF and never wraps.
- Start while busy (any state other than IDLE) is ignored and has no side effects.
- A read of DATA (io_rd & selected & offset 4) clears done at the clock edge. If DONE/FAIL sets done in the same cycle, the set wins.

## Timing
- Reset values: trig_o=0, busy_o=0, io_dout=16'h0000 (unselected address), DATA=0, done=0, timeout=0, state IDLE.
- Reset is honoured in any state. Mid-measurement it drops trig_o on the next edge and discards the partial count.
- Start/trigger: start written at edge N → trig_o and busy_o high from edge N+1. trig_o stays high exactly TRIG_US·CLK_PER_US cycles.
- Echo latency: echo_i edge to state reaction is 2–3 cycles (synchronizer).
- Width resolution: 1 µs; the count is floor-aligned to prescaler ticks (±1 µs).
- DATA and STATUS update at the same edge that busy_o falls.
- Write side effects happen at the clock edge of the io_wr cycle. Reads have no side effects except the DATA read clearing done.

## Test plan
- Reset: hold sys_rst_i 3 cycles → trig_o=0, busy_o=0; reading STATUS (0x6002) returns 16'h0000; reading DATA returns 16'h0000.
- Trigger: defaults, write 16'h0001 to 0x6000 → trig_o high 500 cycles starting the next cycle; STATUS reads 16'h0001 during the trigger.
- Measure: echo_i high for 580 µs after the trigger → DATA reads 580 (±1); STATUS reads 16'h0002; reading DATA then STATUS → 16'h0000.
- Timeout: no echo → 30000 µs after the trigger, STATUS reads 16'h0006 and DATA reads 16'hFFFF. Repeat with echo stuck high → same result.
- Decode and busy: io_wr with data 1 to 0x2000 → no trigger. A second start during MEASURE → ignored; the first result is unaffected.
- Reset mid-MEASURE: assert sys_rst_i → next edge trig_o=0, busy_o=0, DATA=0. A new start then measures correctly.

Source files
------------

// File: rtl/ultrasonic_io_slave.sv
// Ultrasonic ranging peripheral on the J1 I/O bus: it issues the trigger pulse and
// measures the echo pulse width in microseconds, readable through CTRL/STATUS/DATA.
module ultrasonic_io_slave #(
    parameter logic [15:0] BASE_ADDR  = 16'h6000,
    parameter int          CLK_PER_US = 50,
    parameter int          TRIG_US    = 10,
    parameter int          TIMEOUT_US = 30000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_din,
    output logic [15:0] io_dout,
    output logic        trig_o,
    input  logic        echo_i,
    output logic        busy_o
);

    localparam logic [15:0] PRESC_LAST   = 16'(CLK_PER_US - 1);
    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_DONE      = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t      state_q;
    logic        echo_meta_q;
    logic        echo_s_q;
    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic [15:0] us_cnt_q;
    logic [15:0] width_q;
    logic [15:0] data_q;
    logic        done_q;
    logic        timeout_q;
    logic        trig_q;
    logic        busy_q;
    logic [15:0] rdata_s;

    logic sel_s;
    logic start_s;
    logic start_accept_s;
    logic data_rd_s;
    logic tick_s;
    logic unused_s;

    assign sel_s          = (io_addr[15:4] == BASE_ADDR[15:4]);
    assign start_s        = io_wr & sel_s & (io_addr[3:0] == 4'h0) & io_din[0];
    assign start_accept_s = start_s & (state_q == S_IDLE);
    assign data_rd_s      = io_rd & sel_s & (io_addr[3:0] == 4'h4);
    assign tick_s         = (presc_q == PRESC_LAST);
    assign unused_s       = ^io_din[15:1];

    // Register read mux; the CPU samples it in the same cycle it drives the address
    always_comb begin
        rdata_s = 16'h0000;
        if (sel_s) begin
            case (io_addr[3:0])
                4'h2:    rdata_s = {13'b0, timeout_q, done_q, busy_q};
                4'h4:    rdata_s = data_q;
                default: rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign io_dout = rdata_s;
    assign trig_o  = trig_q;
    assign busy_o  = busy_q;

    // Microsecond prescaler next state
    always_comb begin
        presc_d = presc_q + 16'd1;
        if (start_accept_s) begin
            presc_d = 16'd0;
        end else if (tick_s) begin
            presc_d = 16'd0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Echo synchronizer and prescaler registers
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            presc_q     <= 16'd0;
        end else begin
            echo_meta_q <= echo_i;
            echo_s_q    <= echo_meta_q;
            presc_q     <= presc_d;
        end
    end

    // Measurement FSM with registered trigger/busy and result registers
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q   <= S_IDLE;
            us_cnt_q  <= 16'd0;
            width_q   <= 16'd0;
            data_q    <= 16'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // A DATA read acknowledges done; a same-cycle set below overrides it
            if (data_rd_s) begin
                done_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        us_cnt_q  <= 16'd0;
                        width_q   <= 16'd0;
                        trig_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (tick_s) begin
                        if (us_cnt_q == TRIG_LAST) begin
                            us_cnt_q <= 16'd0;
                            trig_q   <= 1'b0;
                            state_q  <= S_WAIT_RISE;
                        end else begin
                            us_cnt_q <= us_cnt_q + 16'd1;
                        end
                    end
                end
                S_WAIT_RISE: begin
                    if (tick_s) begin
                        us_cnt_q <= us_cnt_q + 16'd1;
                    end
                    if (echo_s_q) begin
                        state_q <= S_MEASURE;
                    end else if (tick_s && (us_cnt_q == TIMEOUT_LAST)) begin
                        state_q <= S_FAIL;
                    end
                end
                S_MEASURE: begin
                    if (!echo_s_q) begin
                        state_q <= S_DONE;
                    end else if (tick_s) begin
                        us_cnt_q <= us_cnt_q + 16'd1;
                        if (width_q != 16'hFFFF) begin
                            width_q <= width_q + 16'd1;
                        end
                        if (us_cnt_q == TIMEOUT_LAST) begin
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_DONE: begin
                    data_q  <= width_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    data_q    <= 16'hFFFF;
                    timeout_q <= 1'b1;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_io_slave.sv
// Scoreboard bench for ultrasonic_io_slave: stimulus queues expectations, a negedge
// monitor pops them whenever a bus read or a probe strobe is presented.
module tb_ultrasonic_io_slave;

    localparam int CPU  = 5;
    localparam int TUS  = 10;
    localparam int TOUT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = 16'h0000;
    logic [15:0] io_din = 16'h0000;
    logic [15:0] io_dout;
    logic        trig_o;
    logic        echo = 1'b0;
    logic        busy_o;

    ultrasonic_io_slave #(
        .BASE_ADDR (16'h6000),
        .CLK_PER_US(CPU),
        .TRIG_US   (TUS),
        .TIMEOUT_US(TOUT)
    ) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_din   (io_din),
        .io_dout  (io_dout),
        .trig_o   (trig_o),
        .echo_i   (echo),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    // kind 0: io_dout on a read, kind 1: {trig_o,busy_o}, kind 2: probe_val
    typedef struct {
        int    kind;
        int    lo;
        int    hi;
        string name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   act;
    int   tests = 0;
    int   fails = 0;
    logic probe = 1'b0;
    int   probe_val = 0;
    int   trig_run = 0;
    int   last_trig_len = 0;
    int   trig_pulses = 0;

    always @(negedge clk) begin
        if (trig_o) begin
            trig_run++;
        end else if (trig_run != 0) begin
            last_trig_len = trig_run;
            trig_pulses++;
            trig_run = 0;
        end
    end

    always @(negedge clk) begin
        if (io_rd || probe) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: output presented with no expectation queued");
            end else begin
                e = sb_q.pop_front();
                case (e.kind)
                    0:       act = int'(io_dout);
                    1:       act = int'({trig_o, busy_o});
                    default: act = probe_val;
                endcase
                if (act < e.lo || act > e.hi) begin
                    fails++;
                    $display("FAIL %s: got %0d (0x%0h), expected %0d..%0d", e.name, act, act, e.lo, e.hi);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input int lo, input int hi, input string nm);
        io_addr = a;
        io_rd   = 1'b1;
        sb_q.push_back('{0, lo, hi, nm});
        step(1);
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_addr = a;
        io_din  = d;
        io_wr   = 1'b1;
        step(1);
        io_wr = 1'b0;
    endtask

    task automatic pins(input int v, input string nm);
        probe = 1'b1;
        sb_q.push_back('{1, v, v, nm});
        step(1);
        probe = 1'b0;
    endtask

    task automatic val(input int v, input int lo, input int hi, input string nm);
        probe_val = v;
        probe     = 1'b1;
        sb_q.push_back('{2, lo, hi, nm});
        step(1);
        probe = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) break;
            step(1);
        end
    endtask

    task automatic wait_trig_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!trig_o) break;
            step(1);
        end
        step(1);
    endtask

    task automatic measure(input int width_us);
        wr(16'h6000, 16'h0001);
        wait_trig_low(TUS * CPU + 20);
        step(20);
        echo = 1'b1;
        step(width_us * CPU);
        echo = 1'b0;
        wait_idle(100);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        pins(0, "rst_pins");
        rd(16'h6002, 0, 0, "rst_status");
        rd(16'h6004, 0, 0, "rst_data");
        rd(16'h6000, 0, 0, "ctrl_reads_zero");
        rd(16'h1234, 0, 0, "unselected_read");

        wr(16'h6000, 16'h0001);
        pins(3, "trig_start_pins");
        rd(16'h6002, 1, 1, "trig_status");
        wait_trig_low(TUS * CPU + 20);
        val(last_trig_len, TUS * CPU, TUS * CPU, "trig_len");
        step(20);
        echo = 1'b1;
        step(580 * CPU);
        echo = 1'b0;
        wait_idle(100);
        pins(0, "meas_idle_pins");
        rd(16'h6002, 2, 2, "meas_status");
        rd(16'h6004, 579, 581, "meas_data");
        rd(16'h6002, 0, 0, "status_after_data_rd");
        rd(16'h6004, 579, 581, "meas_data_again");

        wr(16'h6000, 16'h0001);
        wait_idle(CPU * (TUS + TOUT) + 100);
        pins(0, "tmo_idle_pins");
        rd(16'h6002, 6, 6, "tmo_status");
        rd(16'h6004, 16'hFFFF, 16'hFFFF, "tmo_data");
        rd(16'h6002, 4, 4, "tmo_status_after_rd");

        echo = 1'b1;
        wr(16'h6000, 16'h0001);
        wait_idle(CPU * (TUS + TOUT) + 100);
        rd(16'h6002, 6, 6, "stuck_status");
        rd(16'h6004, 16'hFFFF, 16'hFFFF, "stuck_data");
        echo = 1'b0;
        step(5);

        wr(16'h2000, 16'h0001);
        wr(16'h6002, 16'h0001);
        wr(16'h6004, 16'h0001);
        wr(16'h6000, 16'h0000);
        pins(0, "decode_no_trig");
        val(trig_pulses, 3, 3, "decode_pulse_count");
        rd(16'h2004, 0, 0, "unselected_data_addr");

        wr(16'h6000, 16'h0001);
        wait_trig_low(TUS * CPU + 20);
        step(20);
        echo = 1'b1;
        step(100 * CPU);
        wr(16'h6000, 16'h0001);
        pins(1, "start_in_measure_pins");
        step(200 * CPU - 2);
        echo = 1'b0;
        wait_idle(100);
        val(trig_pulses, 4, 4, "no_second_trigger");
        rd(16'h6002, 2, 2, "busy_start_status");
        rd(16'h6004, 299, 301, "busy_start_data");

        wr(16'h6000, 16'h0001);
        wait_trig_low(TUS * CPU + 20);
        step(20);
        echo = 1'b1;
        step(50 * CPU);
        rst = 1'b1;
        step(1);
        pins(0, "rst_mid_pins");
        rst = 1'b0;
        rd(16'h6004, 0, 0, "rst_mid_data");
        rd(16'h6002, 0, 0, "rst_mid_status");
        echo = 1'b0;
        step(5);
        measure(200);
        rd(16'h6002, 2, 2, "after_rst_status");
        rd(16'h6004, 199, 201, "after_rst_data");

        step(3);
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_leftover: %0d expectations never checked, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
